// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, Z/N flags, branch resolution, EX/MEM register, redirect and squash
//
// Ports:
//   clk, rst_n            pipeline clock, asynchronous active-low reset
//   in_valid, in_ctrl_*   ID/EX slot valid and control (aluop, alusrc, branch, btype, jump, mem/wb control)
//   in_pc, in_rs, in_rt,  PC, register operands, extended immediate, destination register
//   in_x, in_rd
//   stall_in / ready_out  memory stage back-pressure; ready_out tells ID/EX to hold when low
//   out_valid, out_ctrl_*, out_alu, out_rt, out_rd
//                         registered EX/MEM payload (out_alu doubles as the memory address)
//   redirect_valid/_pc    one-cycle PC redirect to fetch on a taken branch or jump
//   flag_z, flag_n        current condition flags
module ex_stage #(
    parameter int SQUASH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_ctrl_regwrt,
    input  logic        in_ctrl_memtoreg,
    input  logic        in_ctrl_memrd,
    input  logic        in_ctrl_memwrt,
    input  logic        in_ctrl_branch,
    input  logic        in_ctrl_btype,
    input  logic        in_ctrl_jump,
    input  logic [2:0]  in_ctrl_aluop,
    input  logic        in_ctrl_alusrc,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    input  logic [31:0] in_x,
    input  logic [5:0]  in_rd,
    input  logic        stall_in,
    output logic        ready_out,
    output logic        out_valid,
    output logic        out_ctrl_regwrt,
    output logic        out_ctrl_memtoreg,
    output logic        out_ctrl_memrd,
    output logic        out_ctrl_memwrt,
    output logic [31:0] out_alu,
    output logic [31:0] out_rt,
    output logic [5:0]  out_rd,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flag_z,
    output logic        flag_n
);

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_NOP   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_NEG   = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b110;
    localparam logic [2:0] ALU_PCADD = 3'b111;

    localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_DEPTH);

    logic [2:0]  squash_cnt;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic        accept;
    logic        cond;
    logic        taken;
    logic        flag_upd;

    assign ready_out = !stall_in;
    assign op_b      = in_ctrl_alusrc ? in_x : in_rt;

    always_comb begin
        alu_res = 32'd0;
        case (in_ctrl_aluop)
            ALU_ADD:   alu_res = in_rs + op_b;
            ALU_SUB:   alu_res = in_rs - op_b;
            ALU_AND:   alu_res = in_rs & op_b;
            ALU_NOP:   alu_res = in_rs;
            ALU_OR:    alu_res = in_rs | op_b;
            ALU_NEG:   alu_res = 32'd0 - in_rs;
            ALU_PASSB: alu_res = op_b;
            ALU_PCADD: alu_res = in_pc + op_b;
            default:   alu_res = 32'd0;
        endcase
    end

    // Slots inside the squash window are wrong-path and never accepted.
    assign accept   = in_valid && !stall_in && (squash_cnt == 3'd0);
    // Branch condition looks at the flags from before this edge.
    assign cond     = in_ctrl_btype ? flag_n : flag_z;
    assign taken    = accept && (in_ctrl_jump || (in_ctrl_branch && cond));
    assign flag_upd = accept && in_ctrl_regwrt && !in_ctrl_memtoreg && (in_ctrl_aluop != ALU_NOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash_cnt        <= 3'd0;
            out_valid         <= 1'b0;
            out_ctrl_regwrt   <= 1'b0;
            out_ctrl_memtoreg <= 1'b0;
            out_ctrl_memrd    <= 1'b0;
            out_ctrl_memwrt   <= 1'b0;
            out_alu           <= 32'd0;
            out_rt            <= 32'd0;
            out_rd            <= 6'd0;
            redirect_valid    <= 1'b0;
            redirect_pc       <= 32'd0;
            flag_z            <= 1'b0;
            flag_n            <= 1'b0;
        end else begin
            // taken is never set while stalled, so the pulse always ends after one cycle.
            redirect_valid <= taken;
            if (taken) begin
                redirect_pc <= in_rs;
            end
            if (!stall_in) begin
                if (squash_cnt != 3'd0) begin
                    squash_cnt <= squash_cnt - 3'd1;
                end else if (taken) begin
                    squash_cnt <= SQUASH_LOAD;
                end
                out_valid <= accept;
                if (accept) begin
                    out_ctrl_regwrt   <= in_ctrl_regwrt;
                    out_ctrl_memtoreg <= in_ctrl_memtoreg;
                    out_ctrl_memrd    <= in_ctrl_memrd;
                    out_ctrl_memwrt   <= in_ctrl_memwrt;
                    out_alu           <= alu_res;
                    out_rt            <= in_rt;
                    out_rd            <= in_rd;
                end
                if (flag_upd) begin
                    flag_z <= (alu_res == 32'd0);
                    flag_n <= alu_res[31];
                end
            end
        end
    end

endmodule
